fir_sample_feeder: RTL and testbench

//  Upstream stage of fir_filter. Accepts bursty samples from a source over valid/ready,

---
 rtl/fir_sample_feeder.sv | 118 +++++++++++
 tb/tb_fir_sample_feeder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_feeder.sv
// Sample FIFO feeding fir_filter; releases one sample
// per pulse, pulses at least SPACING clocks apart.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   flush              sync clear of FIFO and pacer
//   in_data/in_valid   source sample handshake
//   in_ready           !full && !flush (0 in reset)
//   input_data         sample to filter, held
//   input_data_flag    one-cycle strobe
//   fill_level         FIFO occupancy 0..DEPTH
module fir_sample_feeder #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int SPACING = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] input_data,
  output logic              input_data_flag,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(SPACING) + 1;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] RELOAD = PW'(SPACING - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     pace_q, pace_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              flag_q, flag_d;

  logic push;
  logic pop;

  // Ready looks only at the registered count,
  // never at a pop happening on the same edge.
  assign in_ready = rst_n && !flush &&
                    (cnt_q != FULL);

  assign push = in_valid && in_ready;

  assign pop = !flush && (pace_q == '0) &&
               (cnt_q != '0);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    pace_d = pace_q;
    data_d = data_q;
    flag_d = 1'b0;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      pace_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
        data_d = mem_q[rptr_q];
        flag_d = 1'b1;
        pace_d = RELOAD;
      end else if (pace_q != '0) begin
        pace_d = pace_q - PW'(1);
      end
      unique case (1'b1)
        (push && !pop): cnt_d = cnt_q + CW'(1);
        (pop && !push): cnt_d = cnt_q - CW'(1);
        default:        cnt_d = cnt_q;
      endcase
    end
  end

  // Storage only; no reset needed on the array.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      pace_q <= '0;
      data_q <= '0;
      flag_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      pace_q <= pace_d;
      data_q <= data_d;
      flag_q <= flag_d;
    end
  end

  assign input_data      = data_q;
  assign input_data_flag = flag_q;
  assign fill_level      = cnt_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: vector table,
// directed corner sequences, random vs queue model.
module tb_fir_sample_feeder;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int SP = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_flag;
  logic [3:0]    fill;

  logic          b_flush = 1'b0;
  logic          b_valid = 1'b0;
  logic [DW-1:0] b_data = '0;
  logic          b_ready;
  logic [DW-1:0] b_out;
  logic          b_flag;
  logic [3:0]    b_fill;

  fir_sample_feeder #(
    .DATA_W(DW), .DEPTH(DEPTH), .SPACING(SP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .input_data(out_data),
    .input_data_flag(out_flag),
    .fill_level(fill)
  );

  fir_sample_feeder #(
    .DATA_W(DW), .DEPTH(DEPTH), .SPACING(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .input_data(b_out),
    .input_data_flag(b_flag),
    .fill_level(b_fill)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string n,
                     input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d",
               n, a, e);
    end
  endtask

  // Reference: a queue of samples plus the earliest
  // cycle number at which the next release may occur.
  logic [DW-1:0] q[$];
  int            cyc = 0;
  int            next_ok = 0;
  logic [DW-1:0] m_data = '0;
  logic          m_flag = 1'b0;

  function automatic int m_ready(input logic f);
    return int'(!f && q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    q.delete();
    cyc = 0;
    next_ok = 0;
    m_data = '0;
    m_flag = 1'b0;
  endtask

  task automatic model_edge(input logic v,
                            input logic [DW-1:0] d,
                            input logic f);
    bit rdy;
    bit rel;
    rdy = !f && q.size() < DEPTH;
    rel = !f && q.size() > 0 && cyc >= next_ok;
    m_flag = 1'b0;
    if (rel) begin
      m_data = q.pop_front();
      m_flag = 1'b1;
      next_ok = cyc + SP;
    end
    if (v && rdy) q.push_back(d);
    if (f) begin
      q.delete();
      next_ok = cyc;
    end
    cyc++;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic v,
                      input logic [DW-1:0] d,
                      input logic f,
                      output logic acc);
    in_valid = v;
    in_data = d;
    flush = f;
    #1;
    acc = v && in_ready;
    chk("in_ready", int'(in_ready), m_ready(f));
    @(posedge clk);
    model_edge(v, d, f);
    #1;
    chk("flag", int'(out_flag), int'(m_flag));
    chk("data", int'(out_data), int'(m_data));
    chk("fill", int'(fill), q.size());
    @(negedge clk);
  endtask

  task automatic go_idle();
    logic a;
    int n;
    n = 0;
    while ((q.size() > 0 || cyc < next_ok) &&
           n < 200) begin
      step(1'b0, '0, 1'b0, a);
      n++;
    end
    chk("idle_bound", int'(n < 200), 1);
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          rdy;
    logic          flg;
    logic [DW-1:0] dat;
    int            fl;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic a;
    int rej;
    int n;

    tbl[0] = '{1'b1, 8'd17, 1'b1, 1'b0, 8'd0, 1};
    tbl[1] = '{1'b1, 8'd18, 1'b1, 1'b1, 8'd17, 1};
    for (int i = 2; i <= 10; i++)
      tbl[i] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd17, 1};
    tbl[11] = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd18, 0};
    tbl[12] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd18, 0};

    #12;
    chk("rst_flag", int'(out_flag), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("rel_ready", int'(in_ready), 1);

    // Cadence table: 17 then 18, SPACING apart.
    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].v;
      in_data = tbl[i].d;
      flush = 1'b0;
      #1;
      chk("t_ready", int'(in_ready), int'(tbl[i].rdy));
      @(posedge clk);
      model_edge(tbl[i].v, tbl[i].d, 1'b0);
      #1;
      chk("t_flag", int'(out_flag), int'(tbl[i].flg));
      chk("t_data", int'(out_data), int'(tbl[i].dat));
      chk("t_fill", int'(fill), tbl[i].fl);
      @(negedge clk);
    end

    // SPACING=1 instance: five consecutive pulses.
    for (int k = 1; k <= 6; k++) begin
      b_valid = (k <= 5);
      b_data = DW'(k);
      @(posedge clk);
      #1;
      if (k >= 2) begin
        chk("s1_flag", int'(b_flag), 1);
        chk("s1_data", int'(b_out), k - 1);
      end
      @(negedge clk);
    end
    b_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("s1_flag_end", int'(b_flag), 0);
    chk("s1_data_end", int'(b_out), 5);
    chk("s1_fill_end", int'(b_fill), 0);
    @(negedge clk);

    // Fill to full behind a blocked pacer.
    go_idle();
    step(1'b1, 8'h20, 1'b0, a);
    for (int k = 1; k <= 8; k++)
      step(1'b1, DW'(8'h20 + k), 1'b0, a);
    chk("full_fill", int'(fill), 8);
    chk("full_ready", int'(in_ready), 0);
    rej = 0;
    a = 1'b0;
    while (!a && rej < 20) begin
      step(1'b1, 8'h29, 1'b0, a);
      if (!a) rej++;
    end
    chk("resume_wait", rej, 3);
    for (int k = 0; k < 100; k++)
      step(1'b0, '0, 1'b0, a);
    chk("drain_fill", int'(fill), 0);

    // Flush while a release is due.
    go_idle();
    for (int k = 0; k < 5; k++)
      step(1'b1, DW'(8'h40 + k), 1'b0, a);
    n = 0;
    while (cyc < next_ok && n < 20) begin
      step(1'b0, '0, 1'b0, a);
      n++;
    end
    chk("pre_flush_fill", int'(fill), 4);
    step(1'b1, 8'h99, 1'b1, a);
    chk("flush_flag", int'(out_flag), 0);
    chk("flush_fill", int'(fill), 0);
    step(1'b1, 8'h55, 1'b0, a);
    step(1'b0, '0, 1'b0, a);
    chk("post_flush_flag", int'(out_flag), 1);
    chk("post_flush_data", int'(out_data), 8'h55);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 99) < 60,
           DW'($urandom),
           $urandom_range(0, 49) == 0, a);

    // Async reset between edges with a pulse live.
    go_idle();
    step(1'b1, 8'h77, 1'b0, a);
    step(1'b1, 8'h78, 1'b0, a);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flag", int'(out_flag), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_fill", int'(fill), 0);
    chk("mid_rst_ready", int'(in_ready), 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++)
      step(k < 2, DW'(8'h30 + k), 1'b0, a);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
